ray_coord_gen: RTL and testbench
================================

RAY_COORD_GEN -- requirements
Module: ray_coord_gen

Interface
REQ-001 Parameter H_RES, default 640: pixels per row.
REQ-002 Parameter V_RES, default 480: rows per frame.
REQ-003 Parameter MAX_INFLIGHT, default 16: maximum rays issued but not yet returned.
REQ-004 Parameter FP_W, default 32: width of the fp type, two's complement.
REQ-005 clk  in  1  single clock; all state changes on the rising edge.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 start  in  1  frame start request; acted on only in IDLE.
REQ-008 x_start, y_start  in  FP_W each  screen coordinates of pixel (0,0).
REQ-009 x_step, y_step  in  FP_W each  per-column and per-row coordinate increments.
REQ-010 hold  in  1  downstream stall; no issue in a cycle where hold=1.
REQ-011 result_valid  in  1  one ray result has returned from the ray unit.
REQ-012 screen_x, screen_y  out  FP_W each  issued ray coordinates.
REQ-013 coords_valid  out  1  screen_x/screen_y/pix_x/pix_y valid this cycle.
REQ-014 pix_x, pix_y  out  $clog2(H_RES), $clog2(V_RES)  integer pixel index of the issued ray.
REQ-015 busy  out  1  high in RUN and DRAIN.
REQ-016 frame_done  out  1  one-cycle pulse when the last result of a frame returns.
REQ-017 underflow  out  1  sticky flag: result_valid seen with zero rays in flight.

Function
REQ-018 FSM states: IDLE, RUN, DRAIN; all outputs registered.
REQ-019 IDLE: when start=1, latch x_start/x_step/y_start/y_step, set x_acc=x_start, y_acc=y_start, x_cnt=0, y_cnt=0, and go to RUN.
REQ-020 Issue condition: state RUN && hold=0 && inflight < MAX_INFLIGHT.
REQ-021 On an issue edge, load screen_x<=x_acc, screen_y<=y_acc, pix_x<=x_cnt, pix_y<=y_cnt and set coords_valid<=1; on every other edge coords_valid<=0.
REQ-022 Advance after issue when x_cnt<H_RES-1: x_cnt+1, x_acc+=x_step.
REQ-023 Advance after issue when x_cnt=H_RES-1 (row wrap): x_cnt=0, x_acc=latched x_start, y_cnt+1, y_acc+=y_step.
REQ-024 Issuing pixel (H_RES-1, V_RES-1) moves the FSM to DRAIN.
REQ-025 fp additions wrap modulo 2^FP_W with no saturation.
REQ-026 inflight counter: +1 on issue, -1 on result_valid; both in the same cycle leave it unchanged.
REQ-027 result_valid with inflight=0 leaves inflight at 0 and sets underflow.
REQ-028 DRAIN: when inflight reaches 0 (including via a same-edge decrement to 0), pulse frame_done for one cycle and return to IDLE.
REQ-029 Latency: start sampled at edge N; first coords_valid=1 after edge N+1 if the issue condition holds.
REQ-030 Throughput: one coordinate per cycle when unstalled.
REQ-031 start in RUN or DRAIN is ignored, and the latched parameters are unchanged.
REQ-032 hold does not affect result_valid accounting.

Reset
REQ-033 rst_n=0 immediately forces IDLE, inflight=0, and the following outputs to 0: coords_valid, screen_x, screen_y, pix_x, pix_y, busy, frame_done, underflow.
REQ-034 Reset mid-frame abandons the frame with no frame_done; results arriving after reset release count as underflow.

Configuration
REQ-035 Macro RAY_COORD_PERF_EN: when defined, add output stall_cycles (32 bits).
REQ-036 stall_cycles is cleared on start accepted in IDLE and increments each RUN cycle in which the issue condition is false; it saturates at all-ones.
REQ-037 When RAY_COORD_PERF_EN is undefined, the stall_cycles port and its logic are absent and behaviour is otherwise identical.

Verification
REQ-038 Full frame: H_RES=4, V_RES=2, x_start=-1.0, x_step=0.5, y_start=1.0, y_step=-1.0, hold=0, results returned 3 cycles after each issue -> 8 consecutive coords_valid.
  - screen_x sequence: -1.0, -0.5, 0.0, 0.5, repeated for each row.
  - screen_y: 1.0 for pix_y=0, 0.0 for pix_y=1.
  - frame_done pulses once, 3 cycles after the last issue.
REQ-039 Inflight limit: MAX_INFLIGHT=2, no results returned -> exactly 2 coords_valid pulses, then none; one result_valid -> exactly one further issue.
REQ-040 hold=1 for 5 cycles mid-row at pix_x=2 -> no coords_valid during hold; resumes at pix_x=2 with no skip or repeat (stall_cycles=5 with RAY_COORD_PERF_EN).
REQ-041 Simultaneous issue and result_valid at inflight=MAX_INFLIGHT-1 -> inflight unchanged; an issue occurs the next cycle.
REQ-042 Reset asserted at pix (1,1) -> all outputs 0 at once, busy=0; a new start issues from pix (0,0); a stale result_valid sets underflow.

Source files
------------

// File: rtl/ray_coord_gen.sv
// Raster ray coordinate generator: walks an H_RES x V_RES frame and issues fixed-point screen coords per pixel.
// Latency: first coords one cycle after start is accepted, then one coordinate per cycle when unstalled.
// Backpressure: no issue while hold=1 or MAX_INFLIGHT rays are outstanding; each result_valid returns one credit.
// Optional feature: define RAY_COORD_PERF_EN to add the stall_cycles performance counter output.
module ray_coord_gen #(
    parameter int H_RES        = 640,
    parameter int V_RES        = 480,
    parameter int MAX_INFLIGHT = 16,
    parameter int FP_W         = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [FP_W-1:0]            x_start,
    input  logic [FP_W-1:0]            y_start,
    input  logic [FP_W-1:0]            x_step,
    input  logic [FP_W-1:0]            y_step,
    input  logic                       hold,
    input  logic                       result_valid,
    output logic [FP_W-1:0]            screen_x,
    output logic [FP_W-1:0]            screen_y,
    output logic                       coords_valid,
    output logic [$clog2(H_RES)-1:0]   pix_x,
    output logic [$clog2(V_RES)-1:0]   pix_y,
    output logic                       busy,
    output logic                       frame_done,
    output logic                       underflow
`ifdef RAY_COORD_PERF_EN
    ,
    output logic [31:0]                stall_cycles
`endif
);
    localparam int PXW = $clog2(H_RES);
    localparam int PYW = $clog2(V_RES);
    localparam int IFW = $clog2(MAX_INFLIGHT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t          state;
    logic [FP_W-1:0] x_start_q;
    logic [FP_W-1:0] x_step_q;
    logic [FP_W-1:0] y_step_q;
    logic [FP_W-1:0] x_acc;
    logic [FP_W-1:0] y_acc;
    logic [PXW-1:0]  x_cnt;
    logic [PYW-1:0]  y_cnt;
    logic [IFW-1:0]  inflight;
    logic [IFW-1:0]  inflight_nxt;
    logic            issue;
    logic            dec;
    logic            last_x;
    logic            last_y;

    assign issue  = (state == S_RUN) && !hold && (inflight < IFW'(MAX_INFLIGHT));
    assign last_x = (x_cnt == PXW'(H_RES - 1));
    assign last_y = (y_cnt == PYW'(V_RES - 1));

    // Credit count: a result with nothing outstanding is dropped (and flagged), never wraps below zero
    always_comb begin
        dec          = result_valid && (inflight != '0);
        inflight_nxt = inflight;
        if (issue && !dec) begin
            inflight_nxt = inflight + 1'b1;
        end else if (!issue && dec) begin
            inflight_nxt = inflight - 1'b1;
        end
    end

    // Frame walk FSM with registered outputs; DRAIN ends on the edge where the count reaches zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            x_start_q    <= '0;
            x_step_q     <= '0;
            y_step_q     <= '0;
            x_acc        <= '0;
            y_acc        <= '0;
            x_cnt        <= '0;
            y_cnt        <= '0;
            inflight     <= '0;
            screen_x     <= '0;
            screen_y     <= '0;
            pix_x        <= '0;
            pix_y        <= '0;
            coords_valid <= 1'b0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            underflow    <= 1'b0;
`ifdef RAY_COORD_PERF_EN
            stall_cycles <= '0;
`endif
        end else begin
            coords_valid <= 1'b0;
            frame_done   <= 1'b0;
            inflight     <= inflight_nxt;
            if (result_valid && (inflight == '0)) begin
                underflow <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        x_start_q <= x_start;
                        x_step_q  <= x_step;
                        y_step_q  <= y_step;
                        x_acc     <= x_start;
                        y_acc     <= y_start;
                        x_cnt     <= '0;
                        y_cnt     <= '0;
                        busy      <= 1'b1;
                        state     <= S_RUN;
`ifdef RAY_COORD_PERF_EN
                        stall_cycles <= '0;
`endif
                    end
                end
                S_RUN: begin
                    if (issue) begin
                        screen_x     <= x_acc;
                        screen_y     <= y_acc;
                        pix_x        <= x_cnt;
                        pix_y        <= y_cnt;
                        coords_valid <= 1'b1;
                        if (last_x) begin
                            x_cnt <= '0;
                            x_acc <= x_start_q;
                            if (last_y) begin
                                state <= S_DRAIN;
                            end else begin
                                y_cnt <= y_cnt + 1'b1;
                                y_acc <= y_acc + y_step_q;
                            end
                        end else begin
                            x_cnt <= x_cnt + 1'b1;
                            x_acc <= x_acc + x_step_q;
                        end
                    end
`ifdef RAY_COORD_PERF_EN
                    else if (stall_cycles != '1) begin
                        stall_cycles <= stall_cycles + 32'd1;
                    end
`endif
                end
                S_DRAIN: begin
                    if (inflight_nxt == '0) begin
                        frame_done <= 1'b1;
                        busy       <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ray_coord_gen.sv
// Scoreboard bench for ray_coord_gen: expected pixel coordinates are queued per frame and popped by a monitor.
// Results are returned by a separate process after a per-issue delay; credits are tracked by an abstract count.
// Directed scenarios cover latency, inflight limit, hold, reset mid-frame and stale results; then random frames.
module tb_ray_coord_gen;
    localparam int H    = 4;
    localparam int V    = 2;
    localparam int MAXI = 4;
    localparam int W    = 32;

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        int          px;
        int          py;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         hold = 1'b0;
    logic         result_valid = 1'b0;
    logic [W-1:0] x_start = '0;
    logic [W-1:0] y_start = '0;
    logic [W-1:0] x_step = '0;
    logic [W-1:0] y_step = '0;
    logic [W-1:0] screen_x;
    logic [W-1:0] screen_y;
    logic         coords_valid;
    logic [1:0]   pix_x;
    logic [0:0]   pix_y;
    logic         busy;
    logic         frame_done;
    logic         underflow;
`ifdef RAY_COORD_PERF_EN
    logic [31:0]  stall_cycles;
`endif

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t exp_q[$];
    int   due_q[$];
    int   last_due = 0;
    int   man_req = 0;
    bit   ret_auto = 1'b0;
    int   ret_min = 3;
    int   ret_max = 3;
    int   tb_inf = 0;
    bit   exp_uf = 1'b0;
    bit   draining = 1'b0;
    bit   rv_prev = 1'b0;
    int   n_issue = 0;
    int   done_cnt = 0;
    int   done_edge = 0;
    int   last_issue_edge = 0;
    int   first_issue_edge = -1;
    int   start_edge = 0;
    int   base_issue = 0;
    int   base_done = 0;

    ray_coord_gen #(.H_RES(H), .V_RES(V), .MAX_INFLIGHT(MAXI), .FP_W(W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .x_start(x_start),
        .y_start(y_start),
        .x_step(x_step),
        .y_step(y_step),
        .hold(hold),
        .result_valid(result_valid),
        .screen_x(screen_x),
        .screen_y(screen_y),
        .coords_valid(coords_valid),
        .pix_x(pix_x),
        .pix_y(pix_y),
        .busy(busy),
        .frame_done(frame_done),
        .underflow(underflow)
`ifdef RAY_COORD_PERF_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: pixel k of a frame sits at column k%H, row k/H; coordinate = origin + index*step mod 2^32
    task automatic push_frame(input logic [31:0] xs, input logic [31:0] xst,
                              input logic [31:0] ys, input logic [31:0] yst);
        for (int k = 0; k < H * V; k++) begin
            exp_t e;
            e.x  = xs + 32'(k % H) * xst;
            e.y  = ys + 32'(k / H) * yst;
            e.px = k % H;
            e.py = k / H;
            exp_q.push_back(e);
        end
    endtask

    task automatic start_frame(input logic [31:0] xs, input logic [31:0] xst,
                               input logic [31:0] ys, input logic [31:0] yst);
        push_frame(xs, xst, ys, yst);
        @(posedge clk); #1;
        x_start = xs;
        x_step  = xst;
        y_start = ys;
        y_step  = yst;
        start   = 1'b1;
        @(posedge clk); #1;
        start            = 1'b0;
        start_edge       = cyc;
        base_issue       = n_issue;
        base_done        = done_cnt;
        first_issue_edge = -1;
    endtask

    task automatic wait_done(input bit rnd, input int budget);
        bit got;
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(posedge clk); #1;
            if (rnd) begin
                hold  = ($urandom_range(99) < 30);
                start = (i == 3);
                if (i == 3) begin
                    x_start = $urandom;
                    x_step  = $urandom;
                    y_start = $urandom;
                    y_step  = $urandom;
                end
            end
            if (done_cnt != base_done) got = 1'b1;
        end
        hold  = 1'b0;
        start = 1'b0;
        check("frame_done_seen", got, 1);
        repeat (3) @(posedge clk);
        #1;
        check("frame_done_once", done_cnt - base_done, 1);
        check("busy_after_frame", busy, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_coords_valid"}, coords_valid, 0);
        check({tag, "_screen_x"}, screen_x, 0);
        check({tag, "_screen_y"}, screen_y, 0);
        check({tag, "_pix_x"}, pix_x, 0);
        check({tag, "_pix_y"}, pix_y, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_underflow"}, underflow, 0);
    endtask

    // Returns one result per cycle at the scheduled edge, or on manual request
    initial begin : returner
        forever begin
            @(posedge clk); #1;
            while (due_q.size() > 0 && due_q[0] <= cyc) void'(due_q.pop_front());
            if (due_q.size() > 0 && due_q[0] == cyc + 1) begin
                result_valid = 1'b1;
                void'(due_q.pop_front());
            end else if (man_req > 0) begin
                result_valid = 1'b1;
                man_req--;
            end else begin
                result_valid = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard on every issue and tracks outstanding rays, frame end and underflow
    initial begin : monitor
        exp_t e;
        int   d;
        bit   ret;
        bit   exp_done;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                tb_inf   = 0;
                exp_uf   = 1'b0;
                draining = 1'b0;
                rv_prev  = 1'b0;
            end else begin
                exp_done = 1'b0;
                ret      = rv_prev;
                if (ret && tb_inf == 0) exp_uf = 1'b1;
                if (coords_valid) begin
                    n_issue++;
                    last_issue_edge = cyc;
                    if (first_issue_edge < 0) first_issue_edge = cyc;
                    check("issue_below_limit", tb_inf < MAXI, 1);
                    check("issue_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("screen_x", screen_x, e.x);
                        check("screen_y", screen_y, e.y);
                        check("pix_x", pix_x, e.px);
                        check("pix_y", pix_y, e.py);
                        if (exp_q.size() == 0) draining = 1'b1;
                    end
                    if (ret_auto) begin
                        d = cyc + int'($urandom_range(ret_max, ret_min));
                        if (d <= last_due) d = last_due + 1;
                        last_due = d;
                        due_q.push_back(d);
                    end
                end
                if (coords_valid && !(ret && tb_inf > 0)) tb_inf++;
                else if (!coords_valid && ret && tb_inf > 0) tb_inf--;
                if (draining && tb_inf == 0) begin
                    exp_done = 1'b1;
                    draining = 1'b0;
                end
                check("frame_done", frame_done, exp_done);
                check("underflow", underflow, exp_uf);
                if (frame_done) begin
                    done_cnt++;
                    done_edge = cyc;
                end
                rv_prev = result_valid;
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int saved_done;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;

        // Full frame: Q16.16 -1.0 + 0.5/col, 1.0 - 1.0/row, results after 3 cycles
        ret_auto = 1'b1; ret_min = 3; ret_max = 3;
        start_frame(32'hFFFF_0000, 32'h0000_8000, 32'h0001_0000, 32'hFFFF_0000);
        check("t1_busy_in_run", busy, 1);
        wait_done(1'b0, 100);
        check("t1_issue_count", n_issue - base_issue, H * V);
        check("t1_first_latency", first_issue_edge - start_edge, 1);
        check("t1_consecutive", last_issue_edge - first_issue_edge, H * V - 1);
        check("t1_done_delay", done_edge - last_issue_edge, 3);

        // Inflight limit with no automatic results, then single and back-to-back credits
        ret_auto = 1'b0;
        start_frame($urandom, $urandom, $urandom, $urandom);
        repeat (10) @(posedge clk);
        #1;
        check("t2_limit_fill", n_issue - base_issue, MAXI);
        man_req = 1;
        repeat (6) @(posedge clk);
        #1;
        check("t2_one_credit", n_issue - base_issue, MAXI + 1);
        man_req = 2;
        repeat (6) @(posedge clk);
        #1;
        check("t2_same_cycle_credit", n_issue - base_issue, MAXI + 3);
        check("t2_no_done", done_cnt - base_done, 0);
        check("t2_busy_stuck", busy, 1);
        #2 rst_n = 1'b0;
        exp_q.delete();
        due_q.delete();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        // Hold for 5 cycles when pix_x=2 is next
        ret_auto = 1'b1; ret_min = 3; ret_max = 3;
        start_frame($urandom, $urandom, $urandom, $urandom);
        @(posedge clk); #1;
        @(posedge clk); #1;
        hold = 1'b1;
        repeat (5) @(posedge clk);
        #1 hold = 1'b0;
        @(negedge clk); #1;
        check("t3_no_issue_in_hold", n_issue - base_issue, 2);
        @(negedge clk); #1;
        check("t3_resume", n_issue - base_issue, 3);
        wait_done(1'b0, 100);
`ifdef RAY_COORD_PERF_EN
        check("t3_stall_cycles", stall_cycles, 5);
`endif

        // Random frames: random origin/steps, hold, result delays, ignored mid-frame start
        for (int f = 0; f < 4; f++) begin
            ret_min = 2; ret_max = 6;
            start_frame($urandom, $urandom, $urandom, $urandom);
            wait_done(1'b1, 300);
        end

        // Reset at pixel (1,1); stale results after release must raise underflow
        ret_min = 3; ret_max = 3;
        start_frame(32'hFFFF_0000, 32'h0000_8000, 32'h0001_0000, 32'hFFFF_0000);
        for (int i = 0; i < 40 && (n_issue - base_issue) < 6; i++) begin
            @(negedge clk); #1;
        end
        check("t5_reached_pixel", n_issue - base_issue, 6);
        check("t5_at_pix_x", pix_x, 1);
        check("t5_at_pix_y", pix_y, 1);
        rst_n = 1'b0;
        #1;
        check_all_zero("t5_async_reset");
        saved_done = done_cnt;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 20 && due_q.size() > 0; i++) begin
            @(posedge clk); #1;
        end
        repeat (3) @(posedge clk);
        #1;
        check("t5_underflow_sticky", underflow, 1);
        check("t5_no_done_after_abort", done_cnt - saved_done, 0);
        check("t5_idle_after_reset", busy, 0);
        start_frame(32'h0000_1000, 32'h0000_0100, 32'h0002_0000, 32'h0000_0200);
        wait_done(1'b0, 100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
